instr_fetch: RTL and testbench

//  Fetch end of the multi-cycle MIPS control interface. The control sequencer consumes op[5:0];

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/instr_fetch_npc_calc.sv | 36 +++
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS control slice.
// Holds the sequencer stage codes, the opcode constants and the fetch FSM
// state type used by instr_fetch.
package cpu_pkg;

  // Sequencer stage codes (cs)
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  // Opcodes seen by the sequencer
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Fetch FSM
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DONE = 2'd2
  } fetch_state_t;

  // Sign-extend a 16-bit immediate and scale it to a word offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_npc_calc.sv
// npc_calc: combinational next-PC selection.
//   pc       in  32  current PC
//   ir       in  32  current instruction
//   f_jmp    in  1   take jump target
//   f_branch in  1   beq flag (taken when zero is also set)
//   zero     in  1   ALU zero result
//   npc      out 32  next PC, word aligned
// Priority: jump > taken branch > pc+4. All arithmetic wraps at 32 bits.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic        f_jmp,
  input  logic        f_branch,
  input  logic        zero,
  output logic [31:0] npc
);

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] sel;

  always_comb begin
    pc4     = pc + 32'd4;
    br_tgt  = pc4 + branch_offset(ir[15:0]);
    jmp_tgt = {pc4[31:28], ir[25:0], 2'b00};
    if (f_jmp)                 sel = jmp_tgt;
    else if (f_branch && zero) sel = br_tgt;
    else                       sel = pc4;
    // Keep the PC word aligned no matter what the target arithmetic gives.
    npc = sel & ~32'd3;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch end of the multi-cycle MIPS control interface.
// Owns PC and IR, runs the req/ack handshake to instruction memory during
// S_IF, stretches S_IF via stall, and commits the next PC in S_WB.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cs                  sequencer stage (S_IF..S_WB)
//   f_jmp, f_branch     control flags from the sequencer (valid S_MEM..S_WB)
//   zero                ALU zero for the current instruction
//   imem_req/addr       instruction read request, address = pc
//   imem_ack/rdata      read response
//   stall               fetch outstanding, sequencer holds S_IF
//   op, ir, pc          opcode, instruction register, program counter
//   imem_err            one-cycle pulse on bus timeout (MAX_WAIT wait cycles)
//   instret, fstall     perf counters (live only with IFETCH_PERF_EN defined,
//                       otherwise tied to 0)
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cs,
  input  logic        f_jmp,
  input  logic        f_branch,
  input  logic        zero,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        stall,
  output logic [5:0]  op,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        imem_err,
  output logic [31:0] instret,
  output logic [31:0] fstall
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  fetch_state_t   state, state_nxt;
  logic           fetching;
  logic           take;
  logic [WCW-1:0] wcnt;
  logic [31:0]    npc;

  npc_calc u_npc (
    .pc       (pc),
    .ir       (ir),
    .f_jmp    (f_jmp),
    .f_branch (f_branch),
    .zero     (zero),
    .npc      (npc)
  );

  // The request goes out in the very first S_IF cycle (from F_IDLE), so a
  // zero-wait memory completes S_IF in one cycle. Reset masks it at once.
  always_comb begin
    fetching  = ~rst & ((state == F_REQ) | ((state == F_IDLE) & (cs == S_IF)));
    take      = fetching & imem_ack;
    imem_req  = fetching;
    imem_addr = pc;
    stall     = fetching & ~imem_ack;
    // Forward the opcode in the ack cycle so the sequencer sees it at that edge.
    op        = take ? imem_rdata[31:26] : ir[31:26];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      F_IDLE:  if (cs == S_IF) state_nxt = imem_ack ? F_DONE : F_REQ;
      F_REQ:   if (imem_ack)   state_nxt = F_DONE;
      F_DONE:  if (cs != S_IF) state_nxt = F_IDLE;
      default: state_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= F_IDLE;
      pc       <= RESET_PC & ~32'd3;
      ir       <= '0;
      wcnt     <= '0;
      imem_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      imem_err <= 1'b0;
      if (take) begin
        ir   <= imem_rdata;
        wcnt <= '0;
      end else if (fetching) begin
        // Timeout: flag it, keep the request up and start counting again.
        if (wcnt == WCW'(MAX_WAIT - 1)) begin
          imem_err <= 1'b1;
          wcnt     <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end else begin
        wcnt <= '0;
      end
      if (cs == S_WB) pc <= npc;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
      fstall  <= '0;
    end else begin
      if (cs == S_WB) instret <= instret + 32'd1;
      if (stall)      fstall  <= fstall + 32'd1;
    end
  end
`else
  assign instret = '0;
  assign fstall  = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. A second instance with a non-zero reset PC
// shares all inputs so the jump-priority case can start from 0x4000_0008.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cs = S_ID;
  logic        f_jmp = 1'b0, f_branch = 1'b0, zero = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic        imem_req, stall, imem_err;
  logic [31:0] imem_addr, ir, pc, instret, fstall;
  logic [5:0]  op;
  logic        imem_req2, stall2, imem_err2;
  logic [31:0] imem_addr2, ir2, pc2, instret2, fstall2;
  logic [5:0]  op2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .cs(cs), .f_jmp(f_jmp), .f_branch(f_branch), .zero(zero),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .op(op), .ir(ir), .pc(pc),
    .imem_err(imem_err), .instret(instret), .fstall(fstall)
  );

  instr_fetch #(.RESET_PC(32'h4000_0008), .MAX_WAIT(15)) dut2 (
    .clk(clk), .rst(rst), .cs(cs), .f_jmp(f_jmp), .f_branch(f_branch), .zero(zero),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall2), .op(op2), .ir(ir2), .pc(pc2),
    .imem_err(imem_err2), .instret(instret2), .fstall(fstall2)
  );

  // Stimulus only: S_IF with nw wait cycles, then ack; ends with cs=S_ID.
  task automatic fetch(input logic [31:0] w, input int nw);
    @(negedge clk); cs = S_IF; imem_rdata = w; imem_ack = 1'b0;
    repeat (nw) @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0; cs = S_ID;
  endtask

  // Stimulus only: S_ID -> S_EX -> S_MEM -> S_WB, flags valid MEM..WB.
  task automatic commit(input logic j, input logic b, input logic z);
    @(negedge clk); cs = S_EX;
    @(negedge clk); cs = S_MEM; f_jmp = j; f_branch = b; zero = z;
    @(negedge clk); cs = S_WB;
    @(negedge clk); cs = S_ID; f_jmp = 1'b0; f_branch = 1'b0; zero = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = S_IF;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    tests++; if (ir !== 32'h0) begin fails++; $display("FAIL reset_ir: got %h want %h", ir, 32'h0); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
    tests++; if (imem_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", imem_err); end
    tests++; if (pc2 !== 32'h4000_0008) begin fails++; $display("FAIL reset_pc2: got %h want %h", pc2, 32'h4000_0008); end
  endtask

  task automatic test_zero_wait();
    @(negedge clk); rst = 1'b0; cs = S_IF; imem_rdata = 32'h2008_0005; imem_ack = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL zw_req: got %b want 1", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL zw_addr: got %h want %h", imem_addr, 32'h0); end
    tests++; if (op !== 6'h08) begin fails++; $display("FAIL zw_op: got %h want %h", op, 6'h08); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL zw_stall: got %b want 0", stall); end
    @(negedge clk); imem_ack = 1'b0; cs = S_ID;
    tests++; if (ir !== 32'h2008_0005) begin fails++; $display("FAIL zw_ir: got %h want %h", ir, 32'h2008_0005); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL zw_req_drop: got %b want 0", imem_req); end
    commit(1'b0, 1'b0, 1'b0);
    tests++; if (pc !== 32'h4) begin fails++; $display("FAIL zw_pc4: got %h want %h", pc, 32'h4); end
  endtask

  task automatic test_wait_states();
    @(negedge clk); cs = S_IF; imem_rdata = 32'h0000_0020; imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL ws_stall[%0d]: got %b want 1", i, stall); end
      tests++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL ws_addr[%0d]: got %h want %h", i, imem_addr, 32'h4); end
      @(posedge clk); #1;
      tests++; if (ir !== 32'h2008_0005) begin fails++; $display("FAIL ws_ir_hold[%0d]: got %h want %h", i, ir, 32'h2008_0005); end
      @(negedge clk);
    end
    imem_ack = 1'b1; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL ws_stall_ack: got %b want 0", stall); end
    tests++; if (op !== 6'h00) begin fails++; $display("FAIL ws_op: got %h want %h", op, 6'h00); end
    @(negedge clk); imem_ack = 1'b0; cs = S_ID;
    tests++; if (ir !== 32'h0000_0020) begin fails++; $display("FAIL ws_ir: got %h want %h", ir, 32'h0000_0020); end
    // Stray ack outside a fetch must be ignored.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stray_req: got %b want 0", imem_req); end
    @(negedge clk); imem_ack = 1'b0;
    tests++; if (ir !== 32'h0000_0020) begin fails++; $display("FAIL stray_ir: got %h want %h", ir, 32'h0000_0020); end
    commit(1'b0, 1'b0, 1'b0);
    tests++; if (pc !== 32'h8) begin fails++; $display("FAIL ws_pc: got %h want %h", pc, 32'h8); end
  endtask

  task automatic test_branch();
    fetch(32'h0, 0); commit(1'b0, 1'b0, 1'b0);
    fetch(32'h0, 0); commit(1'b0, 1'b0, 1'b0);
    tests++; if (pc !== 32'h10) begin fails++; $display("FAIL br_setup_pc: got %h want %h", pc, 32'h10); end
    fetch(32'h1000_FFFF, 0);
    commit(1'b0, 1'b1, 1'b1);
    tests++; if (pc !== 32'h10) begin fails++; $display("FAIL br_taken: got %h want %h", pc, 32'h10); end
    commit(1'b0, 1'b1, 1'b0);
    tests++; if (pc !== 32'h14) begin fails++; $display("FAIL br_not_taken: got %h want %h", pc, 32'h14); end
  endtask

  task automatic test_jump_priority();
    @(negedge clk); rst = 1'b1; cs = S_ID;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++; if (pc2 !== 32'h4000_0008) begin fails++; $display("FAIL jp_reset_pc2: got %h want %h", pc2, 32'h4000_0008); end
    fetch(32'h0800_0100, 0);
    commit(1'b1, 1'b1, 1'b1);
    tests++; if (pc2 !== 32'h4000_0400) begin fails++; $display("FAIL jp_pc2: got %h want %h", pc2, 32'h4000_0400); end
    tests++; if (pc !== 32'h0000_0400) begin fails++; $display("FAIL jp_pc: got %h want %h", pc, 32'h0000_0400); end
  endtask

  task automatic test_timeout();
    logic e;
    @(negedge clk); cs = S_IF; imem_rdata = 32'h8C00_0000; imem_ack = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      e = (k == 15);
      tests++; if (imem_err !== e) begin fails++; $display("FAIL to_err[%0d]: got %b want %b", k, imem_err, e); end
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL to_req[%0d]: got %b want 1", k, imem_req); end
      tests++; if (ir !== 32'h0800_0100) begin fails++; $display("FAIL to_ir[%0d]: got %h want %h", k, ir, 32'h0800_0100); end
    end
    @(negedge clk); imem_ack = 1'b1; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL to_stall_ack: got %b want 0", stall); end
    @(negedge clk); imem_ack = 1'b0; cs = S_ID;
    tests++; if (ir !== 32'h8C00_0000) begin fails++; $display("FAIL to_ir_done: got %h want %h", ir, 32'h8C00_0000); end
    tests++; if (imem_err !== 1'b0) begin fails++; $display("FAIL to_err_done: got %b want 0", imem_err); end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk); cs = S_IF; imem_rdata = 32'hFFFF_FFFF; imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1; imem_ack = 1'b1;
    @(posedge clk); #1;
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rm_pc: got %h want %h", pc, 32'h0); end
    tests++; if (ir !== 32'h0) begin fails++; $display("FAIL rm_ir: got %h want %h", ir, 32'h0); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rm_req: got %b want 0", imem_req); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rm_stall: got %b want 0", stall); end
    @(negedge clk); rst = 1'b0; imem_ack = 1'b0; cs = S_ID; #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rm_req_after: got %b want 0", imem_req); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_ret, exp_stl;
    fetch(32'h2008_0005, 0); commit(1'b0, 1'b0, 1'b0);
    fetch(32'h2008_0005, 1); commit(1'b0, 1'b0, 1'b0);
    fetch(32'h2008_0005, 2); commit(1'b0, 1'b0, 1'b0);
`ifdef IFETCH_PERF_EN
    exp_ret = 32'd3; exp_stl = 32'd3;
`else
    exp_ret = 32'd0; exp_stl = 32'd0;
`endif
    tests++; if (instret !== exp_ret) begin fails++; $display("FAIL perf_instret: got %0d want %0d", instret, exp_ret); end
    tests++; if (fstall !== exp_stl) begin fails++; $display("FAIL perf_fstall: got %0d want %0d", fstall, exp_stl); end
    tests++; if (pc !== 32'hC) begin fails++; $display("FAIL perf_pc: got %h want %h", pc, 32'hC); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_jump_priority();
    test_timeout();
    test_reset_mid_fetch();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
